// File: rtl/filter_controller_pkg.sv
// Shared control definitions for the layer/filter controllers: FSM state type and default counter width.
package filter_controller_pkg;

    localparam int SIZE_W_DEFAULT = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_CONV  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } filt_state_t;

endpackage

// File: rtl/filter_controller_pos.sv
// Row-major output-position counter; latches the map size on clear and flags the last position.
module pos_counter #(
    parameter int SIZE_W = filter_controller_pkg::SIZE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              advance,
    input  logic [SIZE_W-1:0] size,
    output logic [SIZE_W-1:0] row,
    output logic [SIZE_W-1:0] col,
    output logic              last
);

    localparam logic [SIZE_W-1:0] ONE = SIZE_W'(1);

    logic [SIZE_W-1:0] size_q;
    logic [SIZE_W-1:0] size_m1;

    assign size_m1 = size_q - ONE;
    assign last    = (row == size_m1) && (col == size_m1);

    always_ff @(posedge clk) begin
        if (rst) begin
            size_q <= '0;
            row    <= '0;
            col    <= '0;
        end else if (clear) begin
            size_q <= size;
            row    <= '0;
            col    <= '0;
        end else if (advance) begin
            if (col == size_m1) begin
                col <= '0;
                row <= row + ONE;
            end else begin
                col <= col + ONE;
            end
        end
    end

endmodule

// File: rtl/filter_controller.sv
// Sequences load/convolve/write over every output position of one filter, then pulses filterFinish.
// All outputs are registers; each request is a level held until its own finish input is seen.
module filter_controller
    import filter_controller_pkg::*;
#(
    parameter int SIZE_W = SIZE_W_DEFAULT
) (
    input  logic              clk,
    input  logic              resetState,
    input  logic              startFilterConv,
    input  logic [SIZE_W-1:0] outputSize,
    input  logic              windowLoaded,
    input  logic              convFinish,
    input  logic              writeFinish,
    output logic              loadWindow,
    output logic              startConv,
    output logic              writeResult,
    output logic [SIZE_W-1:0] outRow,
    output logic [SIZE_W-1:0] outCol,
    output logic              filterFinish
);

    filt_state_t state;
    logic        pos_clear;
    logic        pos_advance;
    logic        pos_last;

    // Counter control follows the same transitions the FSM takes below.
    assign pos_clear   = (state == ST_IDLE) && startFilterConv;
    assign pos_advance = (state == ST_WRITE) && writeFinish && !pos_last;

    pos_counter #(
        .SIZE_W (SIZE_W)
    ) u_pos (
        .clk     (clk),
        .rst     (resetState),
        .clear   (pos_clear),
        .advance (pos_advance),
        .size    (outputSize),
        .row     (outRow),
        .col     (outCol),
        .last    (pos_last)
    );

    always_ff @(posedge clk) begin
        if (resetState) begin
            state        <= ST_IDLE;
            loadWindow   <= 1'b0;
            startConv    <= 1'b0;
            writeResult  <= 1'b0;
            filterFinish <= 1'b0;
        end else begin
            loadWindow   <= 1'b0;
            startConv    <= 1'b0;
            writeResult  <= 1'b0;
            filterFinish <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (startFilterConv) begin
                        if (outputSize == '0) begin
                            state        <= ST_DONE;
                            filterFinish <= 1'b1;
                        end else begin
                            state      <= ST_LOAD;
                            loadWindow <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (windowLoaded) begin
                        state     <= ST_CONV;
                        startConv <= 1'b1;
                    end else begin
                        loadWindow <= 1'b1;
                    end
                end
                ST_CONV: begin
                    if (convFinish) begin
                        state       <= ST_WRITE;
                        writeResult <= 1'b1;
                    end else begin
                        startConv <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (writeFinish) begin
                        if (pos_last) begin
                            state        <= ST_DONE;
                            filterFinish <= 1'b1;
                        end else begin
                            state      <= ST_LOAD;
                            loadWindow <= 1'b1;
                        end
                    end else begin
                        writeResult <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_filter_controller.sv
// Scoreboard bench: each accepted start queues the expected row-major positions and a finish token.
module tb_filter_controller;
    import filter_controller_pkg::*;

    localparam int W = SIZE_W_DEFAULT;
    localparam int FIN = -1;

    logic         clk = 1'b0;
    logic         resetState = 1'b1;
    logic         startFilterConv = 1'b0;
    logic [W-1:0] outputSize = '0;
    logic         windowLoaded = 1'b0;
    logic         convFinish = 1'b0;
    logic         writeFinish = 1'b0;
    logic         loadWindow, startConv, writeResult, filterFinish;
    logic [W-1:0] outRow, outCol;

    always #5 clk = ~clk;

    filter_controller #(.SIZE_W(W)) dut (
        .clk             (clk),
        .resetState      (resetState),
        .startFilterConv (startFilterConv),
        .outputSize      (outputSize),
        .windowLoaded    (windowLoaded),
        .convFinish      (convFinish),
        .writeFinish     (writeFinish),
        .loadWindow      (loadWindow),
        .startConv       (startConv),
        .writeResult     (writeResult),
        .outRow          (outRow),
        .outCol          (outCol),
        .filterFinish    (filterFinish)
    );

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    bit model_idle = 1'b1;
    int mode = 0;           // 0: answer every request at once, 1: random finish noise, 2: stall in LOAD
    int cyc = 0;
    int run_start = 0;
    int run_size = 0;
    bit run_fast = 1'b0;
    int n_load = 0, n_conv = 0, n_write = 0;
    int accepts = 0;
    int finishes = 0;

    task automatic check(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic pop_check(input string name, input int act);
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: unexpected output %0d with empty scoreboard (t=%0t)", name, act, $time);
        end else begin
            check(name, act, exp_q.pop_front());
        end
    endtask

    // Finish-input responder, driven after the DUT's outputs have settled.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (mode)
                0: begin
                    windowLoaded = loadWindow;
                    convFinish   = startConv;
                    writeFinish  = writeResult;
                end
                1: begin
                    windowLoaded = 1'($urandom_range(1));
                    convFinish   = 1'($urandom_range(1));
                    writeFinish  = 1'($urandom_range(1));
                end
                default: begin
                    windowLoaded = 1'b0;
                    convFinish   = 1'b1;
                    writeFinish  = 1'b1;
                end
            endcase
        end
    end

    // Monitor and reference model, evaluated mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (resetState) begin
                exp_q.delete();
                model_idle = 1'b1;
                run_fast   = 1'b0;
            end else begin
                check("one_active_output",
                      int'((int'(loadWindow) + int'(startConv) + int'(writeResult) + int'(filterFinish)) > 1), 0);
                if (mode != 0) run_fast = 1'b0;
                if (!model_idle) begin
                    n_load  += int'(loadWindow);
                    n_conv  += int'(startConv);
                    n_write += int'(writeResult);
                end
                if (loadWindow) begin
                    if (exp_q.size() == 0) pop_check("load_pos", int'(outRow) * 64 + int'(outCol));
                    else check("load_pos", int'(outRow) * 64 + int'(outCol), exp_q[0]);
                end
                if (writeResult && writeFinish)
                    pop_check("write_pos", int'(outRow) * 64 + int'(outCol));
                if (model_idle && startFilterConv) begin
                    run_size = int'(outputSize);
                    for (int r = 0; r < run_size; r++)
                        for (int c = 0; c < run_size; c++)
                            exp_q.push_back(r * 64 + c);
                    exp_q.push_back(FIN);
                    model_idle = 1'b0;
                    run_start  = cyc;
                    run_fast   = (mode == 0);
                    n_load = 0; n_conv = 0; n_write = 0;
                    accepts++;
                end
                if (filterFinish) begin
                    finishes++;
                    pop_check("finish_token", FIN);
                    if (run_fast) begin
                        check("run_latency", cyc - run_start, 3 * run_size * run_size + 1);
                        check("load_count", n_load, run_size * run_size);
                        check("conv_count", n_conv, run_size * run_size);
                        check("write_count", n_write, run_size * run_size);
                    end
                    model_idle = 1'b1;
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k;
        k = 0;
        while (!(model_idle && exp_q.size() == 0) && k < budget) begin
            tick(1);
            k++;
        end
        if (k >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: timeout after %0d cycles, %0d entries pending", name, budget, exp_q.size());
        end
        tick(1);
    endtask

    task automatic start_run(input int sz);
        outputSize = W'(sz);
        startFilterConv = 1'b1;
        tick(1);
        startFilterConv = 1'b0;
    endtask

    initial begin
        int acc0, fin0, k;
        tick(3);
        check("reset_load", int'(loadWindow), 0);
        check("reset_conv", int'(startConv), 0);
        check("reset_write", int'(writeResult), 0);
        check("reset_finish", int'(filterFinish), 0);
        check("reset_row", int'(outRow), 0);
        check("reset_col", int'(outCol), 0);
        resetState = 1'b0;
        tick(2);

        // 2x2 map with immediate responses, then an empty map.
        mode = 0;
        start_run(2);
        wait_idle("run_2x2", 200);
        start_run(0);
        wait_idle("run_empty", 50);

        // Other finishes asserted while waiting in LOAD must not move the FSM.
        mode = 2;
        start_run(2);
        tick(6);
        check("stall_load", int'(loadWindow), 1);
        check("stall_row", int'(outRow), 0);
        check("stall_col", int'(outCol), 0);
        mode = 0;
        wait_idle("run_stall", 200);

        // Size changed after acceptance; the latched size governs the run.
        outputSize = W'(2);
        startFilterConv = 1'b1;
        tick(1);
        startFilterConv = 1'b0;
        outputSize = W'(5);
        wait_idle("run_size_change", 200);

        // Start held high with 1x1 runs: one run every IDLE+LOAD+CONV+WRITE+DONE = 5 cycles.
        acc0 = accepts;
        fin0 = finishes;
        outputSize = W'(1);
        startFilterConv = 1'b1;
        tick(40);
        startFilterConv = 1'b0;
        wait_idle("run_held_start", 50);
        check("held_start_runs", accepts - acc0, 8);
        check("held_start_finishes", finishes - fin0, 8);

        // Reset while convolving at (1,2) of a 3x3 map.
        start_run(3);
        k = 0;
        while (!(startConv && outRow == W'(1) && outCol == W'(2)) && k < 100) begin
            tick(1);
            k++;
        end
        check("reach_conv_1_2", int'(k < 100), 1);
        fin0 = finishes;
        resetState = 1'b1;
        tick(1);
        resetState = 1'b0;
        check("midreset_conv", int'(startConv), 0);
        check("midreset_write", int'(writeResult), 0);
        check("midreset_load", int'(loadWindow), 0);
        check("midreset_row", int'(outRow), 0);
        check("midreset_col", int'(outCol), 0);
        tick(15);
        check("midreset_no_finish", finishes - fin0, 0);

        // Randomized sizes with random finish noise in every state.
        mode = 1;
        for (int i = 0; i < 20; i++) begin
            start_run(int'($urandom_range(4)));
            wait_idle("run_random", 2000);
            tick(int'($urandom_range(3)));
        end
        mode = 0;
        tick(2);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
